// File: rtl/apb_master.sv
// APB3/APB4 requester: accepts one single-beat command at a time, runs it through
// SETUP and ACCESS with an optional wait-state timeout, and returns a one-cycle response.
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        iPCLK,
  input  logic        iPRESETn,
  input  logic        iCMD_VALID,
  output logic        oCMD_READY,
  input  logic        iCMD_WRITE,
  input  logic [15:0] iCMD_ADDR,
  input  logic [31:0] iCMD_WDATA,
  input  logic [3:0]  iCMD_STRB,
  output logic        oRSP_VALID,
  output logic [31:0] oRSP_RDATA,
  output logic        oRSP_ERR,
  output logic        oRSP_TIMEOUT,
  output logic        oPSEL,
  output logic        oPENABLE,
  output logic        oPWRITE,
  output logic [15:0] oPADDR,
  output logic [31:0] oPWDATA,
  output logic [3:0]  oPSTRB,
  input  logic [31:0] iPRDATA,
  input  logic        iPREADY,
  input  logic        iPSLVERR
);

  localparam int              CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0]   TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_ONE = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   waitCnt_r;
  logic            timeoutHit_s;

  // The counter already holds TIMEOUT wait cycles, so a further low iPREADY aborts.
  assign timeoutHit_s = TO_EN && (waitCnt_r == TO_VAL);

  // Transfer sequencer; every output is a register updated here.
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      state_r      <= IDLE;
      waitCnt_r    <= '0;
      oCMD_READY   <= 1'b1;
      oRSP_VALID   <= 1'b0;
      oRSP_RDATA   <= 32'h0000_0000;
      oRSP_ERR     <= 1'b0;
      oRSP_TIMEOUT <= 1'b0;
      oPSEL        <= 1'b0;
      oPENABLE     <= 1'b0;
      oPWRITE      <= 1'b0;
      oPADDR       <= 16'h0000;
      oPWDATA      <= 32'h0000_0000;
      oPSTRB       <= 4'b0000;
    end else begin
      oRSP_VALID <= 1'b0;
      case (state_r)
        IDLE: begin
          if (iCMD_VALID) begin
            state_r    <= SETUP;
            oCMD_READY <= 1'b0;
            oPSEL      <= 1'b1;
            oPENABLE   <= 1'b0;
            oPWRITE    <= iCMD_WRITE;
            oPADDR     <= iCMD_ADDR;
            oPWDATA    <= iCMD_WRITE ? iCMD_WDATA : 32'h0000_0000;
            oPSTRB     <= iCMD_WRITE ? iCMD_STRB : 4'b0000;
          end
        end
        SETUP: begin
          state_r   <= ACCESS;
          oPENABLE  <= 1'b1;
          waitCnt_r <= '0;
        end
        ACCESS: begin
          if (iPREADY) begin
            state_r      <= IDLE;
            oCMD_READY   <= 1'b1;
            oPSEL        <= 1'b0;
            oPENABLE     <= 1'b0;
            oRSP_VALID   <= 1'b1;
            oRSP_RDATA   <= oPWRITE ? 32'h0000_0000 : iPRDATA;
            oRSP_ERR     <= iPSLVERR;
            oRSP_TIMEOUT <= 1'b0;
          end else if (timeoutHit_s) begin
            state_r      <= IDLE;
            oCMD_READY   <= 1'b1;
            oPSEL        <= 1'b0;
            oPENABLE     <= 1'b0;
            oRSP_VALID   <= 1'b1;
            oRSP_RDATA   <= 32'h0000_0000;
            oRSP_ERR     <= 1'b1;
            oRSP_TIMEOUT <= 1'b1;
          end else if (waitCnt_r != CNT_MAX) begin
            waitCnt_r <= waitCnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          oCMD_READY <= 1'b1;
          oPSEL      <= 1'b0;
          oPENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level reference model plus
// directed scenarios with hand-computed latencies and values.
module tb_apb_master;
  localparam int TO = 16;

  logic        iPCLK, iPRESETn;
  logic        iCMD_VALID, oCMD_READY, iCMD_WRITE;
  logic [15:0] iCMD_ADDR;
  logic [31:0] iCMD_WDATA;
  logic [3:0]  iCMD_STRB;
  logic        oRSP_VALID, oRSP_ERR, oRSP_TIMEOUT;
  logic [31:0] oRSP_RDATA;
  logic        oPSEL, oPENABLE, oPWRITE;
  logic [15:0] oPADDR;
  logic [31:0] oPWDATA;
  logic [3:0]  oPSTRB;
  logic [31:0] iPRDATA;
  logic        iPREADY, iPSLVERR;

  apb_master #(.TIMEOUT(TO)) dut (
    .iPCLK(iPCLK), .iPRESETn(iPRESETn),
    .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY), .iCMD_WRITE(iCMD_WRITE),
    .iCMD_ADDR(iCMD_ADDR), .iCMD_WDATA(iCMD_WDATA), .iCMD_STRB(iCMD_STRB),
    .oRSP_VALID(oRSP_VALID), .oRSP_RDATA(oRSP_RDATA), .oRSP_ERR(oRSP_ERR),
    .oRSP_TIMEOUT(oRSP_TIMEOUT), .oPSEL(oPSEL), .oPENABLE(oPENABLE),
    .oPWRITE(oPWRITE), .oPADDR(oPADDR), .oPWDATA(oPWDATA), .oPSTRB(oPSTRB),
    .iPRDATA(iPRDATA), .iPREADY(iPREADY), .iPSLVERR(iPSLVERR)
  );

  initial iPCLK = 1'b0;
  always #5 iPCLK = ~iPCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge iPCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Completer behaviour: iPREADY rises on ACCESS index readyAt; noise elsewhere.
  int          readyAt = 0;
  logic [31:0] rdScript = 32'h0;
  logic        slvDone = 1'b0;
  logic        forceErr = 1'b0;

  initial begin : slave
    int  accIdx;
    bit  inAccess;
    accIdx = 0;
    inAccess = 1'b0;
    iPREADY = 1'b0; iPRDATA = 32'h0; iPSLVERR = 1'b0;
    forever begin
      @(posedge iPCLK);
      #1;
      if (oPSEL && oPENABLE) begin
        accIdx = inAccess ? accIdx + 1 : 0;
        inAccess = 1'b1;
      end else begin
        inAccess = 1'b0;
      end
      if (inAccess && accIdx >= readyAt) begin
        iPREADY  = 1'b1;
        iPRDATA  = rdScript;
        iPSLVERR = slvDone;
      end else begin
        iPREADY  = inAccess ? 1'b0 : 1'($urandom_range(0, 1));
        iPRDATA  = $urandom;
        iPSLVERR = forceErr ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  // Reference model: a transfer is "age" cycles past its acceptance; age 1 is
  // SETUP, age 2+k is ACCESS wait index k. Response fields persist until replaced.
  bit          mBusy, mRspPend, mW, mErr, mTo;
  int          mAge;
  logic [15:0] mA;
  logic [31:0] mD, mRd;
  logic [3:0]  mS;

  always @(negedge iPCLK) begin
    if (!iPRESETn) begin
      chk("rst_psel", oPSEL, 0);
      chk("rst_penable", oPENABLE, 0);
      chk("rst_rsp_valid", oRSP_VALID, 0);
      chk("rst_rsp_rdata", oRSP_RDATA, 0);
      chk("rst_rsp_err", {oRSP_ERR, oRSP_TIMEOUT}, 0);
      mBusy <= 1'b0; mRspPend <= 1'b0; mAge <= 0;
      mRd <= 32'h0; mErr <= 1'b0; mTo <= 1'b0;
    end else begin
      chk("cmd_ready", oCMD_READY, !mBusy);
      chk("psel", oPSEL, mBusy);
      chk("penable", oPENABLE, mBusy && mAge >= 2);
      chk("rsp_valid", oRSP_VALID, mRspPend);
      chk("rsp_rdata", oRSP_RDATA, mRd);
      chk("rsp_err", oRSP_ERR, mErr);
      chk("rsp_timeout", oRSP_TIMEOUT, mTo);
      if (mBusy) begin
        chk("pwrite", oPWRITE, mW);
        chk("paddr", oPADDR, mA);
        chk("pwdata", oPWDATA, mD);
        chk("pstrb", oPSTRB, mS);
      end
      mRspPend <= 1'b0;
      if (!mBusy) begin
        if (iCMD_VALID) begin
          mBusy <= 1'b1; mAge <= 1;
          mW <= iCMD_WRITE; mA <= iCMD_ADDR;
          mD <= iCMD_WRITE ? iCMD_WDATA : 32'h0;
          mS <= iCMD_WRITE ? iCMD_STRB : 4'h0;
        end
      end else if (mAge == 1) begin
        mAge <= 2;
      end else if (iPREADY) begin
        mBusy <= 1'b0; mRspPend <= 1'b1;
        mRd <= mW ? 32'h0 : iPRDATA; mErr <= iPSLVERR; mTo <= 1'b0;
      end else if (TO != 0 && mAge - 2 == TO) begin
        mBusy <= 1'b0; mRspPend <= 1'b1;
        mRd <= 32'h0; mErr <= 1'b1; mTo <= 1'b1;
      end else begin
        mAge <= mAge + 1;
      end
    end
  end

  int          gAcc, gRsp;
  bit          gRspSeen, gSetupOk, gPselAtRsp;
  logic [15:0] gPaddr;
  logic [31:0] gPwdata, gRdata;
  logic [3:0]  gPstrb;
  logic        gErr, gTo;

  // Issues one command and follows it to its response, recording observations.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int rAt, input logic [31:0] rd,
                       input logic se);
    int n;
    int k;
    readyAt = rAt; rdScript = rd; slvDone = se;
    @(posedge iPCLK); #2;
    iCMD_VALID = 1'b1; iCMD_WRITE = w; iCMD_ADDR = a; iCMD_WDATA = d; iCMD_STRB = s;
    n = 0;
    @(negedge iPCLK);
    while (!oCMD_READY && n < 50) begin
      @(negedge iPCLK);
      n++;
    end
    chk("accepted", oCMD_READY, 1);
    gAcc = cyc;
    @(posedge iPCLK); #2;
    iCMD_VALID = 1'b0; iCMD_WDATA = $urandom; iCMD_ADDR = 16'($urandom);
    k = 0; gRspSeen = 1'b0; gSetupOk = 1'b0;
    while (k < 60 && !gRspSeen) begin
      @(negedge iPCLK);
      k++;
      if (k == 1) gSetupOk = oPSEL && !oPENABLE;
      if (k == 2) begin gPaddr = oPADDR; gPwdata = oPWDATA; gPstrb = oPSTRB; end
      if (oRSP_VALID) begin
        gRspSeen = 1'b1; gRsp = cyc;
        gRdata = oRSP_RDATA; gErr = oRSP_ERR; gTo = oRSP_TIMEOUT; gPselAtRsp = oPSEL;
      end
    end
    chk("rsp_seen", gRspSeen, 1);
  endtask

  initial begin
    int acc[4];
    int rspCnt;
    int n;
    iPRESETn = 1'b0; iCMD_VALID = 1'b0; iCMD_WRITE = 1'b0;
    iCMD_ADDR = 16'h0; iCMD_WDATA = 32'h0; iCMD_STRB = 4'h0;
    #1;
    chk("por_psel", oPSEL, 0);
    chk("por_paddr", oPADDR, 0);
    chk("por_pwdata", oPWDATA, 0);
    chk("por_pstrb_pwrite", {oPSTRB, oPWRITE}, 0);
    repeat (3) @(posedge iPCLK);
    #3 iPRESETn = 1'b1;
    @(negedge iPCLK);
    chk("por_ready", oCMD_READY, 1);

    // Zero-wait write
    issue(1'b1, 16'h0000, 32'h1, 4'hF, 0, 32'h0, 1'b0);
    chk("wr_setup", gSetupOk, 1);
    chk("wr_paddr", gPaddr, 32'h0000);
    chk("wr_pwdata", gPwdata, 32'h1);
    chk("wr_pstrb", gPstrb, 32'hF);
    chk("wr_latency", gRsp - gAcc, 3);
    chk("wr_err", {gErr, gTo}, 0);

    // Read with three wait states
    issue(1'b0, 16'h0100, 32'hDEAD_BEEF, 4'hF, 3, 32'h1234_5678, 1'b0);
    chk("rd_latency", gRsp - gAcc, 6);
    chk("rd_rdata", gRdata, 32'h1234_5678);
    chk("rd_pstrb_pwdata", {gPstrb, gPwdata}, 0);

    // Slave error at completion, then error only during waits
    forceErr = 1'b1;
    issue(1'b0, 16'h0134, 32'h0, 4'h0, 2, 32'hA5A5_0001, 1'b1);
    chk("slverr_err", gErr, 1);
    chk("slverr_to", gTo, 0);
    issue(1'b0, 16'h0134, 32'h0, 4'h0, 2, 32'hA5A5_0002, 1'b0);
    chk("waiterr_err", gErr, 0);
    forceErr = 1'b0;

    // Timeout and its boundaries
    issue(1'b0, 16'h0200, 32'h0, 4'h0, 1000, 32'h5555_5555, 1'b0);
    chk("to_latency", gRsp - gAcc, 19);
    chk("to_flags", {gErr, gTo}, 2'b11);
    chk("to_rdata", gRdata, 0);
    chk("to_psel", gPselAtRsp, 0);
    issue(1'b1, 16'h0204, 32'h7, 4'h3, 15, 32'h0, 1'b0);
    chk("ready16_latency", gRsp - gAcc, 18);
    chk("ready16_to", {gErr, gTo}, 0);
    issue(1'b0, 16'h0208, 32'h0, 4'h0, 16, 32'hCAFE_F00D, 1'b0);
    chk("ready17_latency", gRsp - gAcc, 19);
    chk("ready17_rdata", gRdata, 32'hCAFE_F00D);
    chk("ready17_to", gTo, 0);

    // Back-to-back with iCMD_VALID held high
    readyAt = 0;
    @(posedge iPCLK); #2;
    iCMD_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iCMD_WRITE = 1'(i); iCMD_ADDR = 16'(16'h0300 + 4 * i);
      iCMD_WDATA = $urandom; iCMD_STRB = 4'($urandom);
      n = 0;
      @(negedge iPCLK);
      while (!oCMD_READY && n < 20) begin
        @(negedge iPCLK);
        n++;
      end
      acc[i] = cyc;
      @(posedge iPCLK); #2;
    end
    iCMD_VALID = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[0], 3 * i);
    repeat (4) @(posedge iPCLK);

    // Reset during ACCESS
    readyAt = 1000;
    @(posedge iPCLK); #2;
    iCMD_VALID = 1'b1; iCMD_WRITE = 1'b1; iCMD_ADDR = 16'h0400;
    iCMD_WDATA = 32'h1111_2222; iCMD_STRB = 4'hF;
    @(posedge iPCLK); #2;
    iCMD_VALID = 1'b0;
    repeat (3) @(posedge iPCLK);
    #3 iPRESETn = 1'b0;
    #1;
    chk("arst_psel_pen", {oPSEL, oPENABLE}, 0);
    chk("arst_pwrite", oPWRITE, 0);
    chk("arst_paddr", oPADDR, 0);
    chk("arst_pwdata", oPWDATA, 0);
    chk("arst_pstrb", oPSTRB, 0);
    chk("arst_rsp", {oRSP_VALID, oRSP_ERR, oRSP_TIMEOUT}, 0);
    repeat (2) @(posedge iPCLK);
    #3 iPRESETn = 1'b1;
    readyAt = 0;
    rspCnt = 0;
    repeat (25) begin
      @(negedge iPCLK);
      if (oRSP_VALID) rspCnt++;
    end
    chk("no_rsp_after_rst", rspCnt, 0);
    issue(1'b1, 16'h0500, 32'h8765_4321, 4'h5, 0, 32'h0, 1'b0);
    chk("post_rst_latency", gRsp - gAcc, 3);
    chk("post_rst_paddr", gPaddr, 32'h0500);

    // Randomized traffic, including occasional timeouts
    for (int t = 0; t < 150; t++) begin
      int rAt;
      repeat ($urandom_range(0, 2)) @(posedge iPCLK);
      rAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      issue(1'($urandom), 16'($urandom), $urandom, 4'($urandom), rAt, $urandom, 1'($urandom));
    end
    repeat (3) @(posedge iPCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat commands from an on-chip controller (CPU-bridge or test sequencer) into APB3/APB4 transfers toward slave register blocks such as the stopwatch interface. One command is accepted at a time, driven through SETUP and ACCESS phases with unlimited wait states up to a timeout, then returned as a one-cycle response carrying read data and error status.

## Interface
- TIMEOUT, 16: maximum number of ACCESS cycles with iPREADY low before abort; 0 disables the timeout.
- iPCLK  in  1  APB clock; single clock domain, rising edge.
- iPRESETn  in  1  asynchronous active-low reset.
- iCMD_VALID  in  1  command present.
- oCMD_READY  out  1  block can accept a command.
- iCMD_WRITE  in  1  1 = write, 0 = read.
- iCMD_ADDR  in  16  byte address.
- iCMD_WDATA  in  32  write data.
- iCMD_STRB  in  4  write byte strobes.
- oRSP_VALID  out  1  one-cycle response pulse.
- oRSP_RDATA  out  32  read data; 0 for writes and aborted transfers.
- oRSP_ERR  out  1  iPSLVERR sampled at completion, or timeout.
- oRSP_TIMEOUT  out  1  transfer aborted by timeout.
- oPSEL, oPENABLE, oPWRITE  out  1 each  APB control.
- oPADDR  out  16; oPWDATA  out  32; oPSTRB  out  4  APB address/data/strobe.
- iPRDATA  in  32; iPREADY  in  1; iPSLVERR  in  1  APB completer response.

## Operation
- States: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: oCMD_READY=1. On iCMD_VALID&oCMD_READY, latch command; next state SETUP.
- SETUP: oPSEL=1, oPENABLE=0, oPADDR/oPWRITE/oPWDATA/oPSTRB from latched command; always one cycle; next ACCESS.
- ACCESS: oPSEL=1, oPENABLE=1, address/control/data held stable. On a rising edge with iPREADY=1: capture iPRDATA (reads only), iPSLVERR; go IDLE, drop oPSEL/oPENABLE, pulse oRSP_VALID.
- Reads: oPWDATA=0, oPSTRB=4'b0000. Writes: oPSTRB=iCMD_STRB as latched.
- Wait counter: cleared on entering ACCESS, +1 per ACCESS cycle with iPREADY=0. If TIMEOUT!=0 and counter reaches TIMEOUT with iPREADY still 0: abort to IDLE, oRSP_VALID=1, oRSP_ERR=1, oRSP_TIMEOUT=1, oRSP_RDATA=0. iPREADY=1 in that same cycle wins (normal completion). Counter width ceil(log2(TIMEOUT+1)), saturates, never wraps.
- iPSLVERR/iPRDATA ignored outside ACCESS and when iPREADY=0.
- Commands offered while oCMD_READY=0 are not consumed; source holds them.
- Reset (any state, incl. mid-transfer): state IDLE; oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB, oRSP_VALID, oRSP_RDATA, oRSP_ERR, oRSP_TIMEOUT all 0; oCMD_READY=1 after reset release. Interrupted transfer produces no response.

## Timing
- Cycle 0: command accepted (IDLE). Cycle 1: SETUP. Cycle 2: ACCESS, first iPREADY sample. Zero-wait completion: oRSP_VALID high in cycle 3, concurrent with return to IDLE and oCMD_READY=1.
- N wait states add N cycles; command-to-response latency = 3+N.
- Minimum spacing: one transfer per 3 cycles (next accept in the cycle oRSP_VALID is high).
- oRSP_* fields valid only while oRSP_VALID=1; held until the next response.
- Timeout: with iPREADY stuck 0, oRSP_VALID asserted TIMEOUT+2 cycles after SETUP... i.e. at cycle 2+TIMEOUT+1.

## Test plan
- Write 0x0000 data 0x1 strb 0xF, iPREADY=1 -> SETUP cycle 1, ACCESS cycle 2 with oPADDR=0x0000, oPWDATA=0x1, oPSTRB=0xF; oRSP_VALID cycle 3, oRSP_ERR=0.
- Read 0x0100, iPRDATA=0x1234_5678, iPREADY low 3 cycles -> ACCESS held 4 cycles, oRSP_RDATA=0x12345678 at cycle 6, oPSTRB=0, oPWDATA=0.
- Read 0x0134 with iPSLVERR=1 at completion -> oRSP_ERR=1, oRSP_TIMEOUT=0; iPSLVERR=1 during wait cycles alone -> no effect.
- TIMEOUT=16, iPREADY stuck 0 -> abort after 16 ACCESS cycles, oRSP_ERR=1, oRSP_TIMEOUT=1, oRSP_RDATA=0, oPSEL=0 next cycle; iPREADY=1 on 16th cycle -> normal completion.
- Back-to-back: iCMD_VALID held high with 4 commands, zero wait -> accepts at cycles 0,3,6,9; commands offered in SETUP/ACCESS not consumed.
- Assert iPRESETn low during ACCESS -> all APB and response outputs 0 immediately, no oRSP_VALID after release, next command runs normally.
